// File: rtl/pipe_sched.sv
`default_nettype none
// pipe_sched: round-robin arbiter feeding a DEPTH-stage shared pipeline.
// Rev 1.0 -- initial release.
module pipe_sched #(
   parameter int XLEN  = 32,
   parameter int NREQ  = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*XLEN-1:0]       req_data,
   output logic [NREQ-1:0]            req_ready,
   input  logic                       flush,
   output logic                       out_valid,
   output logic [XLEN-1:0]            out_data,
   output logic [$clog2(NREQ)-1:0]    out_id,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int IDW = $clog2(NREQ);
   localparam int OCW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] vld_nxt;
   logic [XLEN-1:0]  dat [DEPTH];
   logic [IDW-1:0]   sid [DEPTH];
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   ptr_nxt;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   cand;
   logic             gnt_any;
   logic             stall;
   logic             accept;
   logic [OCW-1:0]   occ_nxt;
   logic [XLEN-1:0]  req_word [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_word[g] = req_data[g*XLEN +: XLEN];
   end

   assign stall = vld[DEPTH-1] & ~out_ready;

   // Scan from ptr+NREQ-1 down to ptr so the candidate nearest ptr wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         cand = IDW'((int'(ptr) + k) % NREQ);
         if (req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign accept    = gnt_any & ~stall & ~flush & ~reset;
   assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
   assign ptr_nxt   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);

   always_comb begin
      vld_nxt = vld;
      occ_nxt = '0;
      if (flush) begin
         vld_nxt = '0;
      end else if (!stall) begin
         vld_nxt[0] = accept;
         for (int s = 1; s < DEPTH; s++) begin
            vld_nxt[s] = vld[s-1];
         end
      end
      for (int s = 0; s < DEPTH; s++) begin
         occ_nxt = occ_nxt + OCW'(vld_nxt[s]);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld       <= '0;
         ptr       <= '0;
         occupancy <= '0;
         for (int s = 0; s < DEPTH; s++) begin
            dat[s] <= '0;
            sid[s] <= '0;
         end
      end else begin
         vld       <= vld_nxt;
         occupancy <= occ_nxt;
         // Flush only clears valid bits; payload and pointer are left alone.
         if (!flush && !stall) begin
            if (accept) begin
               dat[0] <= req_word[gnt_idx];
               sid[0] <= gnt_idx;
               ptr    <= ptr_nxt;
            end
            for (int s = 1; s < DEPTH; s++) begin
               dat[s] <= dat[s-1];
               sid[s] <= sid[s-1];
            end
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH-1];
   assign out_id    = sid[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_pipe_sched.sv
`default_nettype none
// tb_pipe_sched: directed self-checking bench for pipe_sched (XLEN=32, NREQ=4, DEPTH=4).
module tb_pipe_sched;

   logic          clock = 1'b0;
   logic          reset;
   logic [3:0]    req_valid;
   logic [127:0]  req_data;
   logic [3:0]    req_ready;
   logic          flush;
   logic          out_valid;
   logic [31:0]   out_data;
   logic [1:0]    out_id;
   logic          out_ready;
   logic [2:0]    occupancy;

   int tests = 0;
   int fails = 0;

   pipe_sched #(.XLEN(32), .NREQ(4), .DEPTH(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      req_valid = 4'h0;
      flush     = 1'b0;
      out_ready = 1'b1;
      req_data  = {32'h103, 32'h102, 32'h101, 32'hA5A5A5A5};

      // Reset state, with requests present
      #1 req_valid = 4'hF;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_req_ready", req_ready, 0);
      step();
      chk("rst_out_valid_edge", out_valid, 0);

      // Single word
      reset = 1'b0;
      req_valid = 4'b0001;
      #1 chk("single_ready", req_ready, 4'b0001);
      step();
      req_valid = 4'h0;
      chk("single_occ1", occupancy, 1);
      chk("single_ov_e1", out_valid, 0);
      step(); chk("single_ov_e2", out_valid, 0);
      step(); chk("single_ov_e3", out_valid, 0);
      step();
      chk("single_ov_e4", out_valid, 1);
      chk("single_data", out_data, 32'hA5A5A5A5);
      chk("single_id", out_id, 0);
      step();
      chk("single_ov_e5", out_valid, 0);
      chk("single_occ0", occupancy, 0);

      // Fairness after a reset pulse restores ptr=0
      req_data[31:0] = 32'h100;
      reset = 1'b1; #1 reset = 1'b0;
      req_valid = 4'hF;
      for (int c = 0; c < 10; c++) begin
         #1 chk("fair_ready", req_ready, 4'b0001 << (c % 4));
         step();
         chk("fair_occ", occupancy, (c < 3) ? c + 1 : 4);
         if (c >= 3) begin
            chk("fair_ov", out_valid, 1);
            chk("fair_id", out_id, (c - 3) % 4);
            chk("fair_data", out_data, 32'h100 + ((c - 3) % 4));
         end
      end

      // Backpressure: words 6..9 (ids 2,3,0,1) in flight, ptr=2
      out_ready = 1'b0;
      #1 chk("bp_ready0", req_ready, 0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp_data", out_data, 32'h102);
         chk("bp_id", out_id, 2);
         chk("bp_occ", occupancy, 4);
         chk("bp_ready", req_ready, 0);
      end
      out_ready = 1'b1;
      req_valid = 4'h0;
      step(); chk("bp_rel_id3", out_id, 3); chk("bp_rel_occ3", occupancy, 3);
      step(); chk("bp_rel_id0", out_id, 0); chk("bp_rel_occ2", occupancy, 2);
      step(); chk("bp_rel_id1", out_id, 1); chk("bp_rel_occ1", occupancy, 1);
      chk("bp_rel_data1", out_data, 32'h101);
      step(); chk("bp_drain_ov", out_valid, 0); chk("bp_drain_occ", occupancy, 0);
      req_valid = 4'hF;
      #1 chk("bp_ptr_kept", req_ready, 4'b0100);

      // Flush with a pending request (grants 2,3,0 fill three stages)
      step(); step(); step();
      chk("fl_occ3", occupancy, 3);
      flush = 1'b1;
      req_valid = 4'b0010;
      #1 chk("fl_ready0", req_ready, 0);
      step();
      flush = 1'b0;
      chk("fl_occ0", occupancy, 0);
      chk("fl_ov0", out_valid, 0);
      #1 chk("fl_grant", req_ready, 4'b0010);
      step();
      req_valid = 4'h0;
      chk("fl_occ1", occupancy, 1);
      step(); chk("fl_ov_a", out_valid, 0);
      step(); chk("fl_ov_b", out_valid, 0);
      step();
      chk("fl_ov_out", out_valid, 1);
      chk("fl_id_out", out_id, 1);
      chk("fl_data_out", out_data, 32'h101);

      // Reset mid-stream while full (grants 2,3,0,1)
      req_valid = 4'hF;
      step(); step(); step(); step();
      chk("rm_occ4", occupancy, 4);
      chk("rm_ov1", out_valid, 1);
      reset = 1'b1;
      #1;
      chk("rm_ov_async", out_valid, 0);
      chk("rm_occ_async", occupancy, 0);
      chk("rm_ready_rst", req_ready, 0);
      #1 reset = 1'b0;
      req_valid = 4'b1001;
      #1 chk("rm_prio0", req_ready, 4'b0001);
      step();
      req_valid = 4'h0;
      chk("rm_occ1", occupancy, 1);
      chk("rm_ov_e1", out_valid, 0);
      step(); chk("rm_ov_e2", out_valid, 0);
      step(); chk("rm_ov_e3", out_valid, 0);
      step();
      chk("rm_ov_e4", out_valid, 1);
      chk("rm_id", out_id, 0);
      chk("rm_data", out_data, 32'h100);
      step();
      chk("rm_ov_e5", out_valid, 0);
      chk("rm_occ0", occupancy, 0);

      // Bubbles with out_ready=0, ptr=1
      out_ready = 1'b0;
      req_valid = 4'b0010;
      #1 chk("bub_ready_a", req_ready, 4'b0010);
      step();
      req_valid = 4'h0;
      step();
      req_valid = 4'b0100;
      #1 chk("bub_ready_b", req_ready, 4'b0100);
      step();
      req_valid = 4'h0;
      step();
      chk("bub_ov", out_valid, 1);
      chk("bub_id", out_id, 1);
      chk("bub_occ2", occupancy, 2);
      req_valid = 4'b1000;
      #1 chk("bub_stall_ready", req_ready, 0);
      req_valid = 4'h0;
      out_ready = 1'b1;
      step(); chk("bub_gap_ov", out_valid, 0); chk("bub_gap_occ", occupancy, 1);
      step();
      chk("bub_w2_ov", out_valid, 1);
      chk("bub_w2_id", out_id, 2);
      chk("bub_w2_data", out_data, 32'h102);
      step(); chk("bub_end_ov", out_valid, 0); chk("bub_end_occ", occupancy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
